// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit and its helpers.
package hazard_pkg;

   typedef enum logic {RUN, LDSTALL} hz_state_t;

   localparam int unsigned REG_ADDR_W_DEF = 3;

   // Encoding the pipeline registers load when told to bubble or flush.
   localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/hazard_match.sv
// Pure combinational load-use comparator; also usable by the forwarding unit.
module hazard_match
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic                  ex_valid,
   input  logic                  ex_is_load,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  lu_hit
);

   logic rs1_match;
   logic rs2_match;

   // Register 0 is an ordinary register here, so no zero-suppression.
   assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
   assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);
   assign lu_hit    = ex_valid && ex_is_load && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/bubble/flush controller for the 16-bit pipeline.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush perf counters.
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int unsigned LOAD_LAT   = 1,
   parameter int unsigned CNT_W      = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic                  ex_valid,
   input  logic                  ex_is_load,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  branch_taken,
   input  logic                  mem_busy,
   output logic                  stall_front,
   output logic                  stall_back,
   output logic                  bubble_ex,
   output logic                  flush_id,
   output logic                  lu_active,
   output logic [15:0]           perf_stall_cycles,
   output logic [15:0]           perf_flushes
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   hz_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lu_hit;

   hazard_match #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_match (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .ex_valid    (ex_valid),
      .ex_is_load  (ex_is_load),
      .ex_rd       (ex_rd),
      .lu_hit      (lu_hit)
   );

   // Controls decode combinationally so a register freezes in the hazard cycle.
   always_comb begin
      stall_front = 1'b0;
      stall_back  = 1'b0;
      bubble_ex   = 1'b0;
      flush_id    = 1'b0;
      state_d     = state_q;
      cnt_d       = cnt_q;
      if (reset) begin
         state_d = RUN;
         cnt_d   = '0;
      end else if (mem_busy) begin
         stall_front = 1'b1;
         stall_back  = 1'b1;
      end else if (branch_taken) begin
         flush_id  = 1'b1;
         bubble_ex = 1'b1;
         state_d   = RUN;
         cnt_d     = '0;
      end else if (state_q == LDSTALL) begin
         stall_front = 1'b1;
         bubble_ex   = 1'b1;
         cnt_d       = cnt_q - CNT_ONE;
         if (cnt_q == CNT_ONE) state_d = RUN;
      end else if (lu_hit) begin
         stall_front = 1'b1;
         bubble_ex   = 1'b1;
         if (LOAD_LAT > 1) begin
            state_d = LDSTALL;
            cnt_d   = CNT_INIT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign lu_active = (state_q == LDSTALL) && !reset;

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_cnt_q;
   logic [15:0] flush_cnt_q;

   // Both counters saturate rather than wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_front && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 16'd1;
         if (flush_id && (flush_cnt_q != '1))    flush_cnt_q <= flush_cnt_q + 16'd1;
      end
   end

   assign perf_stall_cycles = stall_cnt_q;
   assign perf_flushes      = flush_cnt_q;
`else
   assign perf_stall_cycles = '0;
   assign perf_flushes      = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus.
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs1, id_uses_rs2, ex_valid, ex_is_load, branch_taken, mem_busy;

   logic [1:0]  sf, sb, bx, fl, la;
   logic [15:0] ps0, pf0, ps1, pf1;

   int unsigned vec = 0;
   int unsigned err = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.REG_ADDR_W(3), .LOAD_LAT(1), .CNT_W(3)) dut1 (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd), .branch_taken(branch_taken),
      .mem_busy(mem_busy), .stall_front(sf[0]), .stall_back(sb[0]),
      .bubble_ex(bx[0]), .flush_id(fl[0]), .lu_active(la[0]),
      .perf_stall_cycles(ps0), .perf_flushes(pf0));

   hazard_stall_ctrl #(.REG_ADDR_W(3), .LOAD_LAT(3), .CNT_W(3)) dut3 (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd), .branch_taken(branch_taken),
      .mem_busy(mem_busy), .stall_front(sf[1]), .stall_back(sb[1]),
      .bubble_ex(bx[1]), .flush_id(fl[1]), .lu_active(la[1]),
      .perf_stall_cycles(ps1), .perf_flushes(pf1));

   task automatic chk(input string nm, input int d, input logic [15:0] act, input logic [15:0] exp);
      vec++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s dut%0d at %0t: got %h, expected %h", nm, d, $time, act, exp);
      end
   endtask

   // Model: bubbles still owed after the current one, plus counters.
   int unsigned lat [2] = '{1, 3};
   int unsigned owed[2] = '{0, 0};
   int unsigned nowed[2];
   int unsigned mps[2] = '{0, 0};
   int unsigned mpf[2] = '{0, 0};
   int unsigned nps[2], npf[2];

   // Observation tallies used by the literal scenario checks.
   int unsigned bcnt[2], lacnt[2], sbcnt[2], flcnt[2];

   always @(negedge clk) begin
      logic hit;
      logic e_sf, e_sb, e_bx, e_fl, e_la;
      logic [15:0] act_ps, act_pf;
      hit = ex_valid && ex_is_load &&
            ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      for (int d = 0; d < 2; d++) begin
         e_sf = 0; e_sb = 0; e_bx = 0; e_fl = 0;
         e_la = !reset && (owed[d] > 0);
         nowed[d] = owed[d];
         if (reset) nowed[d] = 0;
         else if (mem_busy) begin e_sf = 1; e_sb = 1; end
         else if (branch_taken) begin e_fl = 1; e_bx = 1; nowed[d] = 0; end
         else if (owed[d] > 0) begin e_sf = 1; e_bx = 1; nowed[d] = owed[d] - 1; end
         else if (hit) begin e_sf = 1; e_bx = 1; nowed[d] = lat[d] - 1; end
         if (reset) begin nps[d] = 0; npf[d] = 0; end
         else begin
            nps[d] = (e_sf && mps[d] < 65535) ? mps[d] + 1 : mps[d];
            npf[d] = (e_fl && mpf[d] < 65535) ? mpf[d] + 1 : mpf[d];
         end
         chk("stall_front", d, 16'(sf[d]), 16'(e_sf));
         chk("stall_back",  d, 16'(sb[d]), 16'(e_sb));
         chk("bubble_ex",   d, 16'(bx[d]), 16'(e_bx));
         chk("flush_id",    d, 16'(fl[d]), 16'(e_fl));
         chk("lu_active",   d, 16'(la[d]), 16'(e_la));
         act_ps = (d == 0) ? ps0 : ps1;
         act_pf = (d == 0) ? pf0 : pf1;
`ifdef HAZARD_PERF_CNT_EN
         chk("perf_stall", d, act_ps, 16'(mps[d]));
         chk("perf_flush", d, act_pf, 16'(mpf[d]));
`else
         chk("perf_stall", d, act_ps, 16'h0000);
         chk("perf_flush", d, act_pf, 16'h0000);
`endif
         if (bx[d]) bcnt[d]++;
         if (la[d]) lacnt[d]++;
         if (sb[d]) sbcnt[d]++;
         if (fl[d]) flcnt[d]++;
      end
   end

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         owed[d] = nowed[d];
         mps[d]  = nps[d];
         mpf[d]  = npf[d];
      end
   end

   task automatic clr();
      id_rs1 = 3'd0; id_rs2 = 3'd0; ex_rd = 3'd0;
      id_uses_rs1 = 0; id_uses_rs2 = 0; ex_valid = 0; ex_is_load = 0;
      branch_taken = 0; mem_busy = 0;
   endtask

   task automatic step(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tally_clear();
      for (int d = 0; d < 2; d++) begin
         bcnt[d] = 0; lacnt[d] = 0; sbcnt[d] = 0; flcnt[d] = 0;
      end
   endtask

   // Load in EX writes r3; ID reads r3 via rs1.
   task automatic set_hazard();
      ex_valid = 1; ex_is_load = 1; ex_rd = 3'd3;
      id_rs1 = 3'd3; id_uses_rs1 = 1;
   endtask

   initial begin
      clr();
      reset = 1;
      step(2);
      reset = 0;
      chk("reset_lu_active", 1, 16'(la[1]), 16'h0);
      chk("reset_perf", 1, ps1, 16'h0);
      step(2);

      // Basic load-use hazard, one cycle of stimulus.
      tally_clear();
      set_hazard(); step(1); clr(); step(5);
      chk("lu_bubbles", 0, 16'(bcnt[0]), 16'd1);
      chk("lu_bubbles", 1, 16'(bcnt[1]), 16'd3);
      chk("lu_active_cycles", 0, 16'(lacnt[0]), 16'd0);
      chk("lu_active_cycles", 1, 16'(lacnt[1]), 16'd2);

      // Hazard via rs2 including register 0.
      tally_clear();
      ex_valid = 1; ex_is_load = 1; ex_rd = 3'd0; id_rs2 = 3'd0; id_uses_rs2 = 1; id_rs1 = 3'd5; id_uses_rs1 = 1;
      step(1); clr(); step(5);
      chk("lu_r0_bubbles", 1, 16'(bcnt[1]), 16'd3);

      // Non-load and invalid EX must not stall.
      tally_clear();
      set_hazard(); ex_is_load = 0; step(1);
      set_hazard(); ex_valid = 0; step(1);
      set_hazard(); id_uses_rs1 = 0; step(1);
      clr(); step(2);
      chk("no_hazard_bubbles", 1, 16'(bcnt[1]), 16'd0);

      // Freeze during the second bubble.
      tally_clear();
      set_hazard(); step(1); clr();
      mem_busy = 1; step(2); mem_busy = 0; step(5);
      chk("freeze_bubbles", 1, 16'(bcnt[1]), 16'd3);
      chk("freeze_stall_back", 1, 16'(sbcnt[1]), 16'd2);
      chk("freeze_bubbles", 0, 16'(bcnt[0]), 16'd1);

      // Branch together with a load-use hit.
      tally_clear();
      set_hazard(); branch_taken = 1; step(1); clr(); step(4);
      chk("br_lu_bubbles", 1, 16'(bcnt[1]), 16'd1);
      chk("br_lu_flush", 1, 16'(flcnt[1]), 16'd1);
      chk("br_lu_ldstall", 1, 16'(lacnt[1]), 16'd0);

      // Branch while in LDSTALL aborts the remaining bubble.
      tally_clear();
      set_hazard(); step(1); clr(); branch_taken = 1; step(1); clr(); step(4);
      chk("br_abort_bubbles", 1, 16'(bcnt[1]), 16'd2);
      chk("br_abort_ldstall", 1, 16'(lacnt[1]), 16'd1);

      // Reset one cycle into LDSTALL (two bubbles still owed).
      tally_clear();
      set_hazard(); step(1); clr(); reset = 1; step(1); reset = 0;
      chk("rst_mid_lu_active", 1, 16'(la[1]), 16'h0);
      chk("rst_mid_perf_stall", 1, ps1, 16'h0);
      chk("rst_mid_perf_flush", 1, pf1, 16'h0);
      step(4);
      chk("rst_mid_bubbles", 1, 16'(bcnt[1]), 16'd1);

      // Perf counters: 5 stall cycles and 2 flushes from a clean reset.
      reset = 1; step(1); reset = 0;
      mem_busy = 1; step(5); mem_busy = 0;
      branch_taken = 1; step(2); branch_taken = 0;
`ifdef HAZARD_PERF_CNT_EN
      chk("perf_stall_5", 1, ps1, 16'd5);
      chk("perf_flush_2", 1, pf1, 16'd2);
      mem_busy = 1; step(65540); mem_busy = 0; step(2);
      chk("perf_sat", 1, ps1, 16'hFFFF);
      chk("perf_sat", 0, ps0, 16'hFFFF);
`else
      chk("perf_stall_off", 1, ps1, 16'd0);
      chk("perf_flush_off", 1, pf1, 16'd0);
`endif
      step(2);
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
